// File: rtl/serial_digit_adder_pkg.sv
// rtl/serial_digit_adder_pkg.sv - shared types and sizing helpers for the serial digit adder
//
// Contents:
//   state_t        : controller state encoding (IDLE, RUN, DONE), 2 bits
//   digit_cycles() : number of RUN cycles needed to consume WIDTH bits DIGIT at a time
//   count_width()  : counter width for a given cycle count, never less than 1
//   full_add()     : one full-adder stage, returns {carry_out, sum}

package serial_digit_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int digit_cycles(input int width, input int digit);
        return width / digit;
    endfunction

    // A single-cycle configuration still needs a 1-bit counter so the
    // register declaration stays legal.
    function automatic int count_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        logic s;
        logic co;
        s  = x ^ y ^ c;
        co = (x & y) | (x & c) | (y & c);
        return {co, s};
    endfunction

endpackage

// File: rtl/serial_digit_adder_cell.sv
// rtl/serial_digit_adder_cell.sv - combinational DIGIT-bit ripple adder cell
//
// Module digit_add_cell
// Parameters:
//   DIGIT   : cell width in bits
// Ports:
//   a, b    : in  [DIGIT-1:0] operand digits
//   cin     : in  carry into bit 0
//   s       : out [DIGIT-1:0] digit sum
//   cout    : out carry out of the top bit
//   msb_cin : out carry into the top bit (used for signed overflow)

import serial_digit_adder_pkg::*;

module digit_add_cell #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             msb_cin
);

    // The chain is walked with a local variable so the ripple stays a
    // straight-line expression instead of a self-referencing vector.
    always_comb begin
        logic       c;
        logic [1:0] fa;
        s       = '0;
        msb_cin = 1'b0;
        c       = cin;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                msb_cin = c;
            end
            fa   = full_add(a[i], b[i], c);
            s[i] = fa[0];
            c    = fa[1];
        end
        cout = c;
    end

endmodule

// File: rtl/serial_digit_adder.sv
// rtl/serial_digit_adder.sv - multi-cycle adder processing DIGIT bits per clock
//
// Module serial_digit_adder
// Parameters:
//   WIDTH : operand/result width (>= 2)
//   DIGIT : bits per cycle, must divide WIDTH
// Ports:
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  : operand handshake; operands accepted only in IDLE
//   a, b, cin            : operands and carry-in
//   sub                  : subtract select (only with SERIAL_DIGIT_ADDER_SUB_EN)
//   out_valid / out_ready: result handshake; result held in DONE until taken
//   sum, cout, ovf       : result, unsigned carry-out, signed overflow
// Optional feature macro: SERIAL_DIGIT_ADDER_SUB_EN adds the sub input (a - b).

import serial_digit_adder_pkg::*;

module serial_digit_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = digit_cycles(WIDTH, DIGIT);
    localparam int CW = count_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if ((DIGIT < 1) || (WIDTH < 2) || (WIDTH % DIGIT != 0)) begin : g_bad_params
            $error("serial_digit_adder: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    state_t          state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] cell_s;
    logic             cell_cout;
    logic             cell_msb_cin;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    digit_add_cell #(
        .DIGIT (DIGIT)
    ) u_cell (
        .a       (a_sh[DIGIT-1:0]),
        .b       (b_sh[DIGIT-1:0]),
        .cin     (carry),
        .s       (cell_s),
        .cout    (cell_cout),
        .msb_cin (cell_msb_cin)
    );

    // New digits enter from the top, so after N cycles the first digit
    // computed has reached bit 0.
    generate
        if (N == 1) begin : g_res_single
            assign res_next = cell_s;
        end else begin : g_res_shift
            assign res_next = {cell_s, res[WIDTH-1:DIGIT]};
        end
    endgenerate

    // Subtraction is a + ~b + 1, so only the load values change.
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            res       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        b_sh     <= b_load;
                        carry    <= carry_load;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    res   <= res_next;
                    carry <= cell_cout;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // The cell is working on the top digit this cycle,
                        // so its carries are the word's MSB carries.
                        cout      <= cell_cout;
                        ovf       <= cell_msb_cin ^ cell_cout;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign sum = res;

endmodule

// File: tb/tb_serial_digit_adder.sv
// tb/tb_serial_digit_adder.sv - directed and random checks of serial_digit_adder

module tb_serial_digit_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // instance 0: WIDTH=8, DIGIT=1
    logic       iv1 = 1'b0, ir1, ov1, or1 = 1'b0, cin1 = 1'b0, co1, vf1;
    logic [7:0] a1 = 8'h00, b1 = 8'h00, s1;
    // instance 1: WIDTH=8, DIGIT=4
    logic       iv4 = 1'b0, ir4, ov4, or4 = 1'b0, cin4 = 1'b0, co4, vf4;
    logic [7:0] a4 = 8'h00, b4 = 8'h00, s4;
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    logic sub1 = 1'b0, sub4 = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    serial_digit_adder #(.WIDTH(8), .DIGIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
        .sub(sub1),
`endif
        .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .ovf(vf1)
    );

    serial_digit_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .cin(cin4),
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
        .sub(sub4),
`endif
        .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4), .ovf(vf4)
    );

    // Runs one full transaction; lat=0 means out_valid never came.
    task automatic do_op(input int inst, input logic [7:0] av, input logic [7:0] bv,
                         input logic cv, input logic sv,
                         output logic [7:0] s, output logic co, output logic vf,
                         output int lat);
        @(negedge clk);
        if (inst == 0) begin
            a1 = av; b1 = bv; cin1 = cv; iv1 = 1'b1;
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
            sub1 = sv;
`endif
        end else begin
            a4 = av; b4 = bv; cin4 = cv; iv4 = 1'b1;
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
            sub4 = sv;
`endif
        end
        @(posedge clk);
        #1;
        iv1 = 1'b0;
        iv4 = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if ((inst == 0 && ov1) || (inst != 0 && ov4)) begin
                lat = k;
                break;
            end
        end
        if (inst == 0) begin s = s1; co = co1; vf = vf1; or1 = 1'b1; end
        else           begin s = s4; co = co4; vf = vf4; or4 = 1'b1; end
        @(posedge clk);
        #1;
        or1 = 1'b0;
        or4 = 1'b0;
        if (sv) begin end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (ir1 !== 1'b1 || ov1 !== 1'b0 || s1 !== 8'h00 || co1 !== 1'b0 || vf1 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b, required 1 0 00 0 0",
                     ir1, ov1, s1, co1, vf1);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_add();
        logic [7:0] s; logic co, vf; int lat;
        do_op(0, 8'h3C, 8'h55, 1'b0, 1'b0, s, co, vf, lat);
        n_cmp++;
        if ({s, co, vf} !== {8'h91, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL basic_add: sum=%h cout=%b ovf=%b, required 91 0 1", s, co, vf);
        end
        n_cmp++;
        if (lat !== 8) begin
            n_bad++;
            $display("FAIL basic_latency: got %0d edges, required 8", lat);
        end
        n_cmp++;
        if (ir1 !== 1'b1 || ov1 !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_return_idle: in_ready=%b out_valid=%b, required 1 0", ir1, ov1);
        end
    endtask

    task automatic test_carry_wrap();
        logic [7:0] s; logic co, vf; int lat;
        do_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, s, co, vf, lat);
        n_cmp++;
        if ({s, co, vf} !== {8'h00, 1'b1, 1'b0} || lat !== 8) begin
            n_bad++;
            $display("FAIL wrap_ff_01: sum=%h cout=%b ovf=%b lat=%0d, required 00 1 0 8", s, co, vf, lat);
        end
        do_op(0, 8'h7F, 8'h00, 1'b1, 1'b0, s, co, vf, lat);
        n_cmp++;
        if ({s, co, vf} !== {8'h80, 1'b0, 1'b1} || lat !== 8) begin
            n_bad++;
            $display("FAIL carry_in_7f: sum=%h cout=%b ovf=%b lat=%0d, required 80 0 1 8", s, co, vf, lat);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        a1 = 8'h12; b1 = 8'h34; cin1 = 1'b1; iv1 = 1'b1;
        @(posedge clk);
        #1;
        iv1 = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (ov1) begin lat = k; break; end
        end
        n_cmp++;
        if (lat !== 8) begin
            n_bad++;
            $display("FAIL bp_latency: got %0d edges, required 8", lat);
        end
        for (int c = 0; c < 5; c++) begin
            a1 = 8'hC3 + 8'(c); b1 = 8'h11; iv1 = c[0];
            @(posedge clk);
            #1;
            n_cmp++;
            if (ov1 !== 1'b1 || ir1 !== 1'b0 || s1 !== 8'h47 || co1 !== 1'b0 || vf1 !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold cycle %0d: out_valid=%b in_ready=%b sum=%h cout=%b ovf=%b, required 1 0 47 0 0",
                         c, ov1, ir1, s1, co1, vf1);
            end
        end
        iv1 = 1'b0;
        or1 = 1'b1;
        @(posedge clk);
        #1;
        or1 = 1'b0;
        n_cmp++;
        if (ir1 !== 1'b1 || ov1 !== 1'b0 || s1 !== 8'h47) begin
            n_bad++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b sum=%h, required 1 0 47", ir1, ov1, s1);
        end
        // ignored in_valid pulses must not have started a new operation
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (ir1 !== 1'b1 || ov1 !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_no_ghost_op: in_ready=%b out_valid=%b, required 1 0", ir1, ov1);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [7:0] s; logic co, vf; int lat;
        @(negedge clk);
        a1 = 8'h55; b1 = 8'h0F; cin1 = 1'b0; iv1 = 1'b1;
        @(posedge clk);
        #1;
        iv1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ov1 !== 1'b0 || s1 !== 8'h00 || ir1 !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_op: out_valid=%b sum=%h in_ready=%b, required 0 00 1", ov1, s1, ir1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(0, 8'h01, 8'h02, 1'b0, 1'b0, s, co, vf, lat);
        n_cmp++;
        if ({s, co, vf} !== {8'h03, 1'b0, 1'b0} || lat !== 8) begin
            n_bad++;
            $display("FAIL after_reset_op: sum=%h cout=%b ovf=%b lat=%0d, required 03 0 0 8", s, co, vf, lat);
        end
    endtask

    task automatic test_digit4();
        logic [7:0] s; logic co, vf; int lat;
        do_op(1, 8'hA7, 8'h6B, 1'b1, 1'b0, s, co, vf, lat);
        n_cmp++;
        if ({s, co, vf} !== {8'h13, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL digit4_add: sum=%h cout=%b ovf=%b, required 13 1 0", s, co, vf);
        end
        n_cmp++;
        if (lat !== 2) begin
            n_bad++;
            $display("FAIL digit4_latency: got %0d edges, required 2", lat);
        end
    endtask

    task automatic test_random();
        logic [7:0] s, ra, rb, es; logic co, vf, rc, eco, evf; int lat;
        logic [8:0] full;
        int bad = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            es  = full[7:0];
            eco = full[8];
            evf = (ra[7] == rb[7]) && (es[7] != ra[7]);
            do_op(1, ra, rb, rc, 1'b0, s, co, vf, lat);
            n_cmp++;
            if ({s, co, vf} !== {es, eco, evf} || lat !== 2) begin
                n_bad++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random %h+%h+%b: sum=%h cout=%b ovf=%b lat=%0d, required %h %b %b 2",
                             ra, rb, rc, s, co, vf, lat, es, eco, evf);
            end
        end
    endtask

`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    task automatic test_sub();
        logic [7:0] s; logic co, vf; int lat;
        do_op(0, 8'h05, 8'h07, 1'b0, 1'b1, s, co, vf, lat);
        n_cmp++;
        if ({s, co, vf} !== {8'hFE, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL sub_05_07: sum=%h cout=%b ovf=%b, required fe 0 0", s, co, vf);
        end
        do_op(0, 8'h80, 8'h01, 1'b1, 1'b1, s, co, vf, lat);
        n_cmp++;
        if ({s, co, vf} !== {8'h7F, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL sub_80_01: sum=%h cout=%b ovf=%b, required 7f 1 1", s, co, vf);
        end
        do_op(1, 8'h80, 8'h01, 1'b0, 1'b1, s, co, vf, lat);
        n_cmp++;
        if ({s, co, vf} !== {8'h7F, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL sub4_80_01: sum=%h cout=%b ovf=%b, required 7f 1 1", s, co, vf);
        end
        do_op(0, 8'h10, 8'h01, 1'b1, 1'b0, s, co, vf, lat);
        n_cmp++;
        if ({s, co, vf} !== {8'h12, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL sub0_add: sum=%h cout=%b ovf=%b, required 12 0 0", s, co, vf);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_add();
        test_carry_wrap();
        test_backpressure();
        test_reset_mid_op();
        test_digit4();
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
        test_sub();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
